// File: rtl/nn_layer_sequencer.sv
// 3-layer binary perceptron on one shared MAC; each neuron costs fan-in+1 cycles (39 busy cycles by default).
// No backpressure: the weight RAM must return data one cycle after wt_rd; start is ignored outside IDLE.
module nn_layer_sequencer #(
  parameter int NUM_IN  = 5,
  parameter int L1      = 3,
  parameter int L2      = 4,
  parameter int L3      = 1,
  parameter int Width   = 8,
  parameter int WADDR_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [NUM_IN-1:0]  in,
  output logic [WADDR_W-1:0] wt_addr,
  output logic               wt_rd,
  input  logic [Width-1:0]   wt_data,
  output logic               busy,
  output logic               done,
  output logic [L3-1:0]      out
);
  localparam int B2   = NUM_IN * L1;
  localparam int B3   = B2 + L1 * L2;
  localparam int MAXF = (NUM_IN > L1) ? ((NUM_IN > L2) ? NUM_IN : L2) : ((L1 > L2) ? L1 : L2);
  localparam int MAXN = (L1 > L2) ? ((L1 > L3) ? L1 : L3) : ((L2 > L3) ? L2 : L3);
  localparam int KW   = (MAXF > 1) ? $clog2(MAXF) : 1;
  localparam int NW   = (MAXN > 1) ? $clog2(MAXN) : 1;
  localparam int AW   = Width + 4;

  typedef enum logic [1:0] {IDLE, FETCH, LAST, DONE} state_t;
  state_t state, state_nx;

  logic [1:0]         layer;
  logic [NW-1:0]      n;
  logic [KW-1:0]      k;
  logic [NUM_IN-1:0]  in_q;
  logic [L1-1:0]      buf1;
  logic [L2-1:0]      buf2;
  logic [L3-1:0]      buf3;
  logic [L3-1:0]      buf3_nx;
  logic [AW-1:0]      acc;
  logic [AW-1:0]      term;
  logic [AW-1:0]      acc_sum;
  logic               pend;
  logic               bit_val;
  logic               last_k;
  logic               last_n;
  logic [WADDR_W-1:0] base;
  logic [WADDR_W-1:0] fan;
  logic [KW-1:0]      fan_m1;
  logic [NW-1:0]      cnt_m1;
  logic [MAXF-1:0]    vec;

  // Per-layer geometry and input vector
  always_comb begin
    base   = '0;
    fan    = WADDR_W'(NUM_IN);
    fan_m1 = KW'(NUM_IN - 1);
    cnt_m1 = NW'(L1 - 1);
    vec    = MAXF'(in_q);
    case (layer)
      2'd1: begin
        base   = WADDR_W'(B2);
        fan    = WADDR_W'(L1);
        fan_m1 = KW'(L1 - 1);
        cnt_m1 = NW'(L2 - 1);
        vec    = MAXF'(buf1);
      end
      2'd2: begin
        base   = WADDR_W'(B3);
        fan    = WADDR_W'(L2);
        fan_m1 = KW'(L2 - 1);
        cnt_m1 = NW'(L3 - 1);
        vec    = MAXF'(buf2);
      end
      default: ;
    endcase
  end

  // pend marks that the datum arriving this cycle belongs to an active input bit
  assign term    = pend ? {{(AW - Width){wt_data[Width-1]}}, wt_data} : '0;
  assign acc_sum = acc + term;
  assign bit_val = !acc_sum[AW-1] && (acc_sum != '0);
  assign last_k  = (k == fan_m1);
  assign last_n  = (n == cnt_m1);

  always_comb begin
    buf3_nx = buf3;
    for (int i = 0; i < L3; i++) begin
      if (n == NW'(i)) buf3_nx[i] = bit_val;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    wt_rd    = 1'b0;
    wt_addr  = '0;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      IDLE: if (start) state_nx = FETCH;
      FETCH: begin
        wt_rd   = 1'b1;
        busy    = 1'b1;
        wt_addr = base + WADDR_W'(n) * fan + WADDR_W'(k);
        if (last_k) state_nx = LAST;
      end
      LAST: begin
        busy = 1'b1;
        if (last_n && layer == 2'd2) state_nx = DONE;
        else                         state_nx = FETCH;
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      layer <= '0;
      n     <= '0;
      k     <= '0;
      in_q  <= '0;
      buf1  <= '0;
      buf2  <= '0;
      buf3  <= '0;
      acc   <= '0;
      pend  <= 1'b0;
      out   <= '0;
    end else begin
      pend <= (state == FETCH) && vec[k];
      case (state)
        IDLE: if (start) begin
          in_q  <= in;
          acc   <= '0;
          layer <= '0;
          n     <= '0;
          k     <= '0;
          buf1  <= '0;
          buf2  <= '0;
          buf3  <= '0;
        end
        FETCH: begin
          acc <= acc_sum;
          if (!last_k) k <= k + 1'b1;
        end
        LAST: begin
          acc <= '0;
          k   <= '0;
          for (int i = 0; i < L1; i++) if (layer == 2'd0 && n == NW'(i)) buf1[i] <= bit_val;
          for (int i = 0; i < L2; i++) if (layer == 2'd1 && n == NW'(i)) buf2[i] <= bit_val;
          if (layer == 2'd2) buf3 <= buf3_nx;
          if (last_n) begin
            n <= '0;
            if (layer != 2'd2) layer <= layer + 2'd1;
            // out changes together with the done pulse that follows
            else               out   <= buf3_nx;
          end else begin
            n <= n + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
